decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised, handshaked instruction-decode pipeline stage. Sits between the fetch/instruction register and the register-file/control stage.
- Splits an instruction word into opcode, rs, rt, rd, shamt, funct, immediate and jump-target fields, and classifies the instruction as R, I or J type.
- Produces sign- and zero-extended immediates.
- Registers all results behind a valid/ready interface with a 2-entry skid buffer, flush support and an accepted-instruction counter.

Parameters:
- INSTR_W, 32, instruction word width.
- OP_W, 6, opcode width (MSBs of word).
- REG_W, 6, width of each of rs/rt/rd.
- SHAMT_W, 4, shift-amount width.
- FUNCT_W, 4, function-code width (LSBs of word).
- IMM_W, 14, immediate width (LSBs of word).
- DATA_W, 32, datapath width for PC and extended immediates.
- R_OPCODE, 0, opcode marking R-type.
- JMP_OPCODE, 2, opcode for jump (J-type).
- JAL_OPCODE, 3, opcode for jump-and-link (J-type).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  INSTR_W  instruction word.
- in_pc  in  DATA_W  PC of instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- opcode  out  OP_W  bits [INSTR_W-1 -: OP_W].
- rs  out  REG_W  next REG_W bits below opcode.
- rt  out  REG_W  next REG_W bits below rs.
- rd  out  REG_W  next REG_W bits below rt.
- shamt  out  SHAMT_W  next SHAMT_W bits below rd.
- funct  out  FUNCT_W  bits [FUNCT_W-1:0].
- imediato  out  IMM_W  bits [IMM_W-1:0], raw.
- imm_sext  out  DATA_W  imediato sign-extended.
- imm_zext  out  DATA_W  imediato zero-extended.
- salto  out  INSTR_W-OP_W  bits [INSTR_W-OP_W-1:0].
- instr_type  out  2  0=R, 1=I, 2=J; 3 never driven.
- out_pc  out  DATA_W  PC travelling with the bundle.
- decoded_count  out  32  number of out handshakes completed.

Behaviour:
- Elaboration checks (fatal on failure):
  - OP_W + 3*REG_W + SHAMT_W + FUNCT_W == INSTR_W.
  - IMM_W <= INSTR_W - OP_W - 2*REG_W.
  - IMM_W <= DATA_W.
- Reset (reset=1 at clock edge): out_valid=0, skid empty, in_ready=1, decoded_count=0, all field outputs, out_pc and instr_type = 0. Reset overrides flush and all handshakes.
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - out_valid and the bundle hold stable while out_valid=1 & out_ready=0.
- Latency: an instruction accepted at edge N is visible at outputs after edge N (1 cycle) when the output register is free. All outputs are flop outputs; no combinational path from in_* or out_ready to outputs.
- Storage: output register (decoded bundle) plus skid register (raw in_instr + in_pc). Decode is applied when data loads into the output register.
- Per edge, in priority order:
  1. If flush: out_valid=0 and skid emptied. An input handshake in the same cycle is discarded. The output handshake, if any, still counts. in_ready=1 next cycle.
  2. If the output register is empty or its handshake fires:
     - If skid is full, skid loads the output register and empties. A simultaneous input goes into the skid.
     - Otherwise, the input (if any) loads the output register.
     - Otherwise, out_valid goes to 0.
  3. If the output register is held (valid, not ready) and an input handshake fires, the input goes into the skid.
- in_ready = !skid_full, registered. When the skid is full, in_ready=0 and in_valid is ignored.
- Ordering: strict FIFO; no instruction is dropped except by flush or reset.
- instr_type:
  - R if opcode==R_OPCODE.
  - J if opcode==JMP_OPCODE or JAL_OPCODE.
  - I otherwise.
  - All fields are decoded regardless of type.
- imm_sext replicates imediato[IMM_W-1] into the upper bits; imm_zext fills them with 0.
- decoded_count increments by 1 per output handshake and wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then in_instr=0x00108304, in_pc=0x40, out_ready=1 -> one cycle later out_valid=1, opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=4, imediato=0x0304, instr_type=0, out_pc=0x40, decoded_count=1 after the handshake.
- in_instr=0x20108FFF… corrected to 0x2010BFFF -> opcode=8, rs=1, rt=2, imediato=0x3FFF, imm_sext=0xFFFFFFFF, imm_zext=0x00003FFF, instr_type=1.
- in_instr=0x08000ABC and 0x0C000ABC -> salto=0x0000ABC, instr_type=2 for both.
- out_ready=0, present A, B, C back-to-back -> A held on outputs, B in skid, in_ready=0, C not accepted. Raise out_ready -> outputs A, B, C in order with no loss or duplication; decoded_count=3.
- Fill output register and skid, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, the flushed instruction never appears.
- Preload decoded_count to 0xFFFFFFFF via 2^32 handshakes (or force), complete one more handshake -> decoded_count=0. Assert reset mid-stream -> all outputs 0 and in_ready=1 at the next edge.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Handshaked instruction-decode stage: splits an instruction into fields, classifies it as R/I/J,
// and registers the decoded bundle behind valid/ready with a one-entry skid register.
module decode_stage_pipe #(
  parameter int INSTR_W    = 32,
  parameter int OP_W       = 6,
  parameter int REG_W      = 6,
  parameter int SHAMT_W    = 4,
  parameter int FUNCT_W    = 4,
  parameter int IMM_W      = 14,
  parameter int DATA_W     = 32,
  parameter int R_OPCODE   = 0,
  parameter int JMP_OPCODE = 2,
  parameter int JAL_OPCODE = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]         in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_W-1:0]           opcode,
  output logic [REG_W-1:0]          rs,
  output logic [REG_W-1:0]          rt,
  output logic [REG_W-1:0]          rd,
  output logic [SHAMT_W-1:0]        shamt,
  output logic [FUNCT_W-1:0]        funct,
  output logic [IMM_W-1:0]          imediato,
  output logic [DATA_W-1:0]         imm_sext,
  output logic [DATA_W-1:0]         imm_zext,
  output logic [INSTR_W-OP_W-1:0]   salto,
  output logic [1:0]                instr_type,
  output logic [DATA_W-1:0]         out_pc,
  output logic [31:0]               decoded_count
);

  localparam int SALTO_W = INSTR_W - OP_W;
  localparam int RS_LSB  = INSTR_W - OP_W - REG_W;
  localparam int RT_LSB  = RS_LSB - REG_W;
  localparam int RD_LSB  = RT_LSB - REG_W;
  localparam int SH_LSB  = RD_LSB - SHAMT_W;

  if (OP_W + 3*REG_W + SHAMT_W + FUNCT_W != INSTR_W) begin : g_chk_fields
    $fatal(1, "decode_stage_pipe: field widths do not sum to INSTR_W");
  end
  if (IMM_W > INSTR_W - OP_W - 2*REG_W) begin : g_chk_imm
    $fatal(1, "decode_stage_pipe: IMM_W overlaps rs/rt");
  end
  if (IMM_W > DATA_W) begin : g_chk_data
    $fatal(1, "decode_stage_pipe: IMM_W wider than DATA_W");
  end

  logic                 out_valid_q, out_valid_d;
  logic                 skid_valid_q, skid_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0]    skid_pc_q, skid_pc_d;
  logic [OP_W-1:0]      opcode_q, opcode_d;
  logic [REG_W-1:0]     rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [SHAMT_W-1:0]   shamt_q, shamt_d;
  logic [FUNCT_W-1:0]   funct_q, funct_d;
  logic [IMM_W-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0]    sext_q, sext_d, zext_q, zext_d, pc_q, pc_d;
  logic [SALTO_W-1:0]   salto_q, salto_d;
  logic [1:0]           type_q, type_d;
  logic [31:0]          count_q, count_d;

  logic                 in_hs, out_hs, ld_out, ld_from_skid;
  logic [INSTR_W-1:0]   ld_instr;
  logic [DATA_W-1:0]    ld_pc;
  logic [OP_W-1:0]      ld_op;

  // Handshake/occupancy control, then decode of whichever word enters the output register
  always_comb begin
    in_hs        = in_valid & in_ready_q;
    out_hs       = out_valid_q & out_ready;
    ld_out       = 1'b0;
    ld_from_skid = 1'b0;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    count_d      = count_q + 32'(out_hs);

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        ld_out       = 1'b1;
        ld_from_skid = 1'b1;
        out_valid_d  = 1'b1;
        skid_valid_d = in_hs;
        if (in_hs) begin
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end else begin
          skid_instr_d = skid_instr_q;
        end
      end else if (in_hs) begin
        ld_out      = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    in_ready_d = !skid_valid_d;

    ld_instr = ld_from_skid ? skid_instr_q : in_instr;
    ld_pc    = ld_from_skid ? skid_pc_q : in_pc;
    ld_op    = ld_instr[INSTR_W-1 -: OP_W];

    opcode_d = opcode_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    shamt_d  = shamt_q;
    funct_d  = funct_q;
    imm_d    = imm_q;
    sext_d   = sext_q;
    zext_d   = zext_q;
    salto_d  = salto_q;
    type_d   = type_q;
    pc_d     = pc_q;
    if (ld_out) begin
      opcode_d = ld_op;
      rs_d     = ld_instr[RS_LSB +: REG_W];
      rt_d     = ld_instr[RT_LSB +: REG_W];
      rd_d     = ld_instr[RD_LSB +: REG_W];
      shamt_d  = ld_instr[SH_LSB +: SHAMT_W];
      funct_d  = ld_instr[FUNCT_W-1:0];
      imm_d    = ld_instr[IMM_W-1:0];
      sext_d   = DATA_W'($signed(ld_instr[IMM_W-1:0]));
      zext_d   = DATA_W'(ld_instr[IMM_W-1:0]);
      salto_d  = ld_instr[SALTO_W-1:0];
      pc_d     = ld_pc;
      if (ld_op == OP_W'(R_OPCODE)) begin
        type_d = 2'd0;
      end else if (ld_op == OP_W'(JMP_OPCODE) || ld_op == OP_W'(JAL_OPCODE)) begin
        type_d = 2'd2;
      end else begin
        type_d = 2'd1;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers; reset clears everything and takes precedence over flush
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      opcode_q     <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      funct_q      <= '0;
      imm_q        <= '0;
      sext_q       <= '0;
      zext_q       <= '0;
      salto_q      <= '0;
      type_q       <= 2'd0;
      pc_q         <= '0;
      count_q      <= 32'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      opcode_q     <= opcode_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      shamt_q      <= shamt_d;
      funct_q      <= funct_d;
      imm_q        <= imm_d;
      sext_q       <= sext_d;
      zext_q       <= zext_d;
      salto_q      <= salto_d;
      type_q       <= type_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign opcode        = opcode_q;
  assign rs            = rs_q;
  assign rt            = rt_q;
  assign rd            = rd_q;
  assign shamt         = shamt_q;
  assign funct         = funct_q;
  assign imediato      = imm_q;
  assign imm_sext      = sext_q;
  assign imm_zext      = zext_q;
  assign salto         = salto_q;
  assign instr_type    = type_q;
  assign out_pc        = pc_q;
  assign decoded_count = count_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe with default parameters.
module tb_decode_stage_pipe;
  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, imm_sext, imm_zext, out_pc, decoded_count;
  logic [5:0]  opcode, rs, rt, rd;
  logic [3:0]  shamt, funct;
  logic [13:0] imediato;
  logic [25:0] salto;
  logic [1:0]  instr_type;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  decode_stage_pipe dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imediato(imediato), .imm_sext(imm_sext), .imm_zext(imm_zext), .salto(salto),
    .instr_type(instr_type), .out_pc(out_pc), .decoded_count(decoded_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    step(); step();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    checks++; if (decoded_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %h expected 0", decoded_count); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
  endtask

  task automatic test_rtype();
    in_valid = 1'b1; in_instr = 32'h00108304; in_pc = 32'h40; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL r_valid: got %b expected 1", out_valid); end
    checks++; if ({opcode, rs, rt, rd} !== {6'd0, 6'd1, 6'd2, 6'd3}) begin errors++; $display("FAIL r_regs: got %h expected %h", {opcode, rs, rt, rd}, {6'd0, 6'd1, 6'd2, 6'd3}); end
    checks++; if ({shamt, funct} !== {4'd0, 4'd4}) begin errors++; $display("FAIL r_shfn: got %h expected 04", {shamt, funct}); end
    checks++; if (imediato !== 14'h0304) begin errors++; $display("FAIL r_imm: got %h expected 0304", imediato); end
    checks++; if (instr_type !== 2'd0) begin errors++; $display("FAIL r_type: got %0d expected 0", instr_type); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL r_pc: got %h expected 40", out_pc); end
    checks++; if (decoded_count !== 32'd0) begin errors++; $display("FAIL r_count0: got %h expected 0", decoded_count); end
    step();
    checks++; if (decoded_count !== 32'd1) begin errors++; $display("FAIL r_count1: got %h expected 1", decoded_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL r_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_itype();
    in_valid = 1'b1; in_instr = 32'h2010BFFF; in_pc = 32'h44;
    step();
    in_valid = 1'b0;
    checks++; if ({opcode, rs, rt} !== {6'd8, 6'd1, 6'd2}) begin errors++; $display("FAIL i_regs: got %h expected %h", {opcode, rs, rt}, {6'd8, 6'd1, 6'd2}); end
    checks++; if (imediato !== 14'h3FFF) begin errors++; $display("FAIL i_imm: got %h expected 3fff", imediato); end
    checks++; if (imm_sext !== 32'hFFFFFFFF) begin errors++; $display("FAIL i_sext: got %h expected ffffffff", imm_sext); end
    checks++; if (imm_zext !== 32'h00003FFF) begin errors++; $display("FAIL i_zext: got %h expected 00003fff", imm_zext); end
    checks++; if (instr_type !== 2'd1) begin errors++; $display("FAIL i_type: got %0d expected 1", instr_type); end
    step();
    checks++; if (decoded_count !== 32'd2) begin errors++; $display("FAIL i_count: got %h expected 2", decoded_count); end
  endtask

  task automatic test_jtype();
    in_valid = 1'b1; in_instr = 32'h08000ABC; in_pc = 32'h80;
    step();
    checks++; if (opcode !== 6'd2 || salto !== 26'h0000ABC) begin errors++; $display("FAIL j_jmp: got op %0d salto %h expected op 2 salto 0000abc", opcode, salto); end
    checks++; if (instr_type !== 2'd2) begin errors++; $display("FAIL j_jmp_type: got %0d expected 2", instr_type); end
    in_instr = 32'h0C000ABC; in_pc = 32'h84;
    step();
    in_valid = 1'b0;
    checks++; if (opcode !== 6'd3 || salto !== 26'h0000ABC) begin errors++; $display("FAIL j_jal: got op %0d salto %h expected op 3 salto 0000abc", opcode, salto); end
    checks++; if (instr_type !== 2'd2) begin errors++; $display("FAIL j_jal_type: got %0d expected 2", instr_type); end
    checks++; if (out_pc !== 32'h84 || decoded_count !== 32'd3) begin errors++; $display("FAIL j_pc_cnt: got %h/%0d expected 84/3", out_pc, decoded_count); end
    step();
    checks++; if (decoded_count !== 32'd4) begin errors++; $display("FAIL j_count: got %h expected 4", decoded_count); end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000001; in_pc = 32'h100;
    step();
    checks++; if (out_pc !== 32'h100 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_a: got pc %h rdy %b expected 100/1", out_pc, in_ready); end
    in_instr = 32'h00000002; in_pc = 32'h104;
    step();
    checks++; if (out_pc !== 32'h100 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_skid: got pc %h rdy %b expected 100/0", out_pc, in_ready); end
    in_instr = 32'h00000003; in_pc = 32'h108;
    step();
    checks++; if (out_pc !== 32'h100 || funct !== 4'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold: got pc %h fn %0d v %b rdy %b expected 100/1/1/0", out_pc, funct, out_valid, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h104 || funct !== 4'd2 || in_ready !== 1'b1 || decoded_count !== 32'd1) begin errors++; $display("FAIL b2b_b: got pc %h fn %0d rdy %b cnt %0d expected 104/2/1/1", out_pc, funct, in_ready, decoded_count); end
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h108 || funct !== 4'd3 || decoded_count !== 32'd2) begin errors++; $display("FAIL b2b_c: got pc %h fn %0d cnt %0d expected 108/3/2", out_pc, funct, decoded_count); end
    step();
    checks++; if (out_valid !== 1'b0 || decoded_count !== 32'd3) begin errors++; $display("FAIL b2b_end: got v %b cnt %0d expected 0/3", out_valid, decoded_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00000005; in_pc = 32'h200;
    step();
    in_pc = 32'h204;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_full: got %b expected 0", in_ready); end
    in_pc = 32'h208; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_clear: got v %b rdy %b expected 0/1", out_valid, in_ready); end
    in_valid = 1'b1; in_pc = 32'h20C; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_input: got %b expected 0", out_valid); end
    out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0 || decoded_count !== 32'd3) begin errors++; $display("FAIL fl_gone: got v %b cnt %0d expected 0/3", out_valid, decoded_count); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000006; in_pc = 32'h300;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b expected 1", out_valid); end
    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    step();
    checks++; if (decoded_count !== 32'd0) begin errors++; $display("FAIL wr_count: got %h expected 0", decoded_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h400;
    step(); step();
    out_ready = 1'b0;
    step();
    checks++; if (in_ready !== 1'b0 || decoded_count !== 32'd1 || opcode !== 6'h3F) begin errors++; $display("FAIL rm_pre: got rdy %b cnt %0d op %h expected 0/1/3f", in_ready, decoded_count, opcode); end
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || decoded_count !== 32'd0) begin errors++; $display("FAIL rm_ctl: got v %b rdy %b cnt %0d expected 0/1/0", out_valid, in_ready, decoded_count); end
    checks++; if ({opcode, rs, rt, rd, shamt, funct, imediato} !== 48'd0 || salto !== 26'd0) begin errors++; $display("FAIL rm_fields: got %h/%h expected 0", {opcode, rs, rt, rd, shamt, funct, imediato}, salto); end
    checks++; if (imm_sext !== 32'd0 || imm_zext !== 32'd0 || out_pc !== 32'd0 || instr_type !== 2'd0) begin errors++; $display("FAIL rm_ext: got %h %h %h %0d expected 0", imm_sext, imm_zext, out_pc, instr_type); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_jtype();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
